// File: rtl/prog_timer_pkg.sv
// prog_timer_pkg: shared types and constants for the programmable timeout timer.
//   state_t        : timer FSM states (ST_IDLE, ST_RUN)
//   TICK_DIV_1MS   : default prescaler divide (1 ms base tick at 1 MHz)
//   CNT_W_DEF      : default tick-count width
//   presc_width()  : prescaler counter width for a given divide ratio
package prog_timer_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  localparam int unsigned TICK_DIV_1MS = 1000;
  localparam int unsigned CNT_W_DEF    = 16;

  function automatic int unsigned presc_width(input int unsigned div);
    return (div < 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk by TICK_DIV while run is high, emitting a base tick.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   run   : advance the prescaler (timer running and enabled)
//   clear : synchronous clear to 0, overrides run
//   tick  : one-cycle pulse in the cycle the prescaler wraps from TICK_DIV-1 to 0
module tick_prescaler
  import prog_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_1MS
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned PW = presc_width(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
    end
  end

  // Tick is decoded from the registered count so it coincides with the wrap edge.
  assign tick = run && !clear && (cnt == LAST);

endmodule

// File: rtl/prog_timeout_timer.sv
// prog_timeout_timer: prescaled, loadable down-counter with one-shot / periodic modes.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   enable     : high = count, low = pause (start/stop still honoured)
//   start      : load load_val/periodic and (re)start counting
//   stop       : abort to idle; wins over start
//   periodic   : sampled with start, 1 = auto-reload
//   load_val   : ticks to timeout, 0 treated as 1
//   timeout    : one-cycle registered pulse at expiry
//   busy       : registered, high while running
//   remaining  : ticks left in the current period, 0 when idle
// Optional (PROG_TIMER_STICKY_EN defined):
//   clr_flag     : clears timeout_flag
//   timeout_flag : sticky record of any timeout; set wins over clear
module prog_timeout_timer
  import prog_timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_1MS,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [CNT_W-1:0] load_val,
`ifdef PROG_TIMER_STICKY_EN
  input  logic             clr_flag,
  output logic             timeout_flag,
`endif
  output logic             timeout,
  output logic             busy,
  output logic [CNT_W-1:0] remaining
);

  state_t           state;
  logic             mode_periodic;
  logic [CNT_W-1:0] reload;
  logic [CNT_W-1:0] eff_load;
  logic             run;
  logic             tick;
  logic             expire;

  assign eff_load = (load_val == '0) ? CNT_W'(1) : load_val;
  assign run      = (state == ST_RUN) && enable;
  // Expiry is suppressed by stop or start on the same edge.
  assign expire   = (state == ST_RUN) && tick && !stop && !start &&
                    (remaining <= CNT_W'(1));

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_presc (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .clear(start || stop),
    .tick (tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      mode_periodic <= 1'b0;
      reload        <= '0;
      remaining     <= '0;
      timeout       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (stop) begin
        state     <= ST_IDLE;
        remaining <= '0;
        busy      <= 1'b0;
      end else if (start) begin
        state         <= ST_RUN;
        reload        <= eff_load;
        remaining     <= eff_load;
        mode_periodic <= periodic;
        busy          <= 1'b1;
      end else if (expire) begin
        timeout <= 1'b1;
        if (mode_periodic) begin
          remaining <= reload;
        end else begin
          state     <= ST_IDLE;
          remaining <= '0;
          busy      <= 1'b0;
        end
      end else if ((state == ST_RUN) && tick) begin
        remaining <= remaining - CNT_W'(1);
      end
    end
  end

`ifdef PROG_TIMER_STICKY_EN
  // Set from the expiry condition so the flag rises together with the pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout_flag <= 1'b0;
    end else if (expire) begin
      timeout_flag <= 1'b1;
    end else if (clr_flag) begin
      timeout_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_prog_timeout_timer.sv
// Directed testbench for prog_timeout_timer with TICK_DIV=4, CNT_W=16.
// Inputs change and outputs are sampled on the falling edge; "k" counts rising
// edges after the start edge E0 (k=0 is the start edge itself).
module tb_prog_timeout_timer;

  localparam int unsigned TD = 4;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          periodic = 1'b0;
  logic [CW-1:0] load_val = '0;
  logic          timeout;
  logic          busy;
  logic [CW-1:0] remaining;
`ifdef PROG_TIMER_STICKY_EN
  logic          clr_flag = 1'b0;
  logic          timeout_flag;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  prog_timeout_timer #(
    .TICK_DIV(TD),
    .CNT_W   (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .start       (start),
    .stop        (stop),
    .periodic    (periodic),
    .load_val    (load_val),
`ifdef PROG_TIMER_STICKY_EN
    .clr_flag    (clr_flag),
    .timeout_flag(timeout_flag),
`endif
    .timeout     (timeout),
    .busy        (busy),
    .remaining   (remaining)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Applies start on the next rising edge (E0); returns at the falling edge after E0.
  task automatic do_start(input logic [CW-1:0] lv, input logic per);
    load_val = lv;
    periodic = per;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #12;
    tests++;
    if ({timeout, busy, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL reset_outputs: got to=%b busy=%b rem=%0d, want 0 0 0", timeout, busy, remaining);
    end
    @(negedge clk);
    rst = 1'b1;
    step();
    tests++;
    if (busy !== 1'b0 || remaining !== 16'd0) begin
      fails++;
      $display("FAIL idle_after_reset: got busy=%b rem=%0d, want 0 0", busy, remaining);
    end
  endtask

  task automatic test_oneshot();
    int exp_rem;
    do_start(16'd5, 1'b0);
    tests++;
    if (busy !== 1'b1 || remaining !== 16'd5) begin
      fails++;
      $display("FAIL oneshot_load: got busy=%b rem=%0d, want 1 5", busy, remaining);
    end
    for (int k = 1; k <= 26; k++) begin
      step();
      exp_rem = (k < 20) ? 5 - k / 4 : 0;
      tests++;
      if (timeout !== (k == 20) || busy !== (k < 20) || remaining !== CW'(exp_rem)) begin
        fails++;
        $display("FAIL oneshot k=%0d: got to=%b busy=%b rem=%0d, want to=%b busy=%b rem=%0d",
                 k, timeout, busy, remaining, k == 20, k < 20, exp_rem);
      end
    end
  endtask

  task automatic test_periodic();
    int exp_rem;
    do_start(16'd3, 1'b1);
    for (int k = 1; k <= 42; k++) begin
      if (k == 30) stop = 1'b1;
      step();
      stop = 1'b0;
      exp_rem = (k < 30) ? 3 - (k % 12) / 4 : 0;
      tests++;
      if (timeout !== (k == 12 || k == 24) || busy !== (k < 30) || remaining !== CW'(exp_rem)) begin
        fails++;
        $display("FAIL periodic k=%0d: got to=%b busy=%b rem=%0d, want to=%b busy=%b rem=%0d",
                 k, timeout, busy, remaining, (k == 12 || k == 24), k < 30, exp_rem);
      end
    end
  endtask

  task automatic test_pause();
    int p;
    int exp_rem;
    do_start(16'd5, 1'b0);
    for (int k = 1; k <= 33; k++) begin
      if (k == 7) enable = 1'b0;
      if (k == 17) enable = 1'b1;
      step();
      p = (k <= 6) ? k : (k <= 16) ? 6 : k - 10;
      exp_rem = (p < 20) ? 5 - p / 4 : 0;
      tests++;
      if (timeout !== (k == 30) || remaining !== CW'(exp_rem)) begin
        fails++;
        $display("FAIL pause k=%0d: got to=%b rem=%0d, want to=%b rem=%0d",
                 k, timeout, remaining, k == 30, exp_rem);
      end
    end
  endtask

  task automatic test_load_zero();
    do_start(16'd0, 1'b0);
    tests++;
    if (remaining !== 16'd1) begin
      fails++;
      $display("FAIL load_zero_rem: got %0d, want 1", remaining);
    end
    for (int k = 1; k <= 7; k++) begin
      step();
      tests++;
      if (timeout !== (k == 4) || busy !== (k < 4)) begin
        fails++;
        $display("FAIL load_zero k=%0d: got to=%b busy=%b, want to=%b busy=%b",
                 k, timeout, busy, k == 4, k < 4);
      end
    end
  endtask

  task automatic test_back_to_back();
    // start and stop together while running: stop wins
    do_start(16'd5, 1'b0);
    repeat (6) step();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    tests++;
    if (busy !== 1'b0 || remaining !== 16'd0 || timeout !== 1'b0) begin
      fails++;
      $display("FAIL start_stop: got busy=%b rem=%0d to=%b, want 0 0 0", busy, remaining, timeout);
    end
    for (int k = 0; k < 24; k++) begin
      step();
      tests++;
      if (timeout !== 1'b0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL start_stop_idle i=%0d: got to=%b busy=%b, want 0 0", k, timeout, busy);
      end
    end
    // restart on the expiry edge: load 2 expires at k=8, restart with load 3 there
    do_start(16'd2, 1'b0);
    for (int k = 1; k <= 22; k++) begin
      if (k == 8) begin
        load_val = 16'd3;
        start    = 1'b1;
      end
      step();
      start = 1'b0;
      tests++;
      if (timeout !== (k == 20)) begin
        fails++;
        $display("FAIL restart k=%0d: got to=%b, want %b", k, timeout, k == 20);
      end
      if (k == 8) begin
        tests++;
        if (remaining !== 16'd3 || busy !== 1'b1) begin
          fails++;
          $display("FAIL restart_load: got rem=%0d busy=%b, want 3 1", remaining, busy);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    do_start(16'd5, 1'b0);
    repeat (19) step();
    @(posedge clk);
    #2;
    tests++;
    if (timeout !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_timeout: got %b, want 1", timeout);
    end
    rst = 1'b0;
    #1;
    tests++;
    if ({timeout, busy, remaining} !== {1'b0, 1'b0, 16'd0}) begin
      fails++;
      $display("FAIL async_reset: got to=%b busy=%b rem=%0d, want 0 0 0", timeout, busy, remaining);
    end
`ifdef PROG_TIMER_STICKY_EN
    tests++;
    if (timeout_flag !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_flag: got %b, want 0", timeout_flag);
    end
`endif
    @(negedge clk);
    rst = 1'b1;
    step();
  endtask

`ifdef PROG_TIMER_STICKY_EN
  task automatic test_sticky();
    do_start(16'd1, 1'b0);
    repeat (3) step();
    tests++;
    if (timeout_flag !== 1'b0) begin
      fails++;
      $display("FAIL flag_early: got %b, want 0", timeout_flag);
    end
    step();
    tests++;
    if (timeout_flag !== 1'b1 || timeout !== 1'b1) begin
      fails++;
      $display("FAIL flag_set: got flag=%b to=%b, want 1 1", timeout_flag, timeout);
    end
    do_stop();
    do_start(16'd5, 1'b0);
    tests++;
    if (timeout_flag !== 1'b1) begin
      fails++;
      $display("FAIL flag_hold: got %b, want 1", timeout_flag);
    end
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    tests++;
    if (timeout_flag !== 1'b0) begin
      fails++;
      $display("FAIL flag_clear: got %b, want 0", timeout_flag);
    end
    do_stop();
    // clear on the expiry edge: set wins
    do_start(16'd1, 1'b0);
    repeat (3) step();
    clr_flag = 1'b1;
    step();
    clr_flag = 1'b0;
    tests++;
    if (timeout_flag !== 1'b1) begin
      fails++;
      $display("FAIL flag_set_wins: got %b, want 1", timeout_flag);
    end
  endtask
`endif

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog: got timeout, want completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_oneshot();
    test_periodic();
    test_pause();
    test_load_zero();
    test_back_to_back();
`ifdef PROG_TIMER_STICKY_EN
    test_sticky();
`endif
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
